arbitro_sumador: RTL and testbench
==================================

// Module: arbitro_sumador
// PURPOSE
//  Round-robin arbiter sharing one pipelined 4-bit adder (sumador) among N_REQ requesters.
//  Grants one operand pair per cycle, drives the adder inputs and tracks the requester ID of
//  each in-flight operation in a tag pipe matching adder latency. Returns each sum, tagged,
//  to its requester. Sits between requester logic and sumador; owns start/stop/drain sequencing.
// PARAMETERS
//  N_REQ   4  number of requesters (2..8)
//  LAT     2  adder latency, cycles from dataA/dataB to sum30_dd (must match sumador)
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  reset_L    in   1        asynchronous, active-low reset
//  enable     in   1        IDLE->RUN request
//  stop       in   1        RUN->DRAIN request
//  req_valid  in   N_REQ    requester i has operands
//  req_dataA  in   4*N_REQ  operand A, requester i in bits [4i+3:4i]
//  req_dataB  in   4*N_REQ  operand B, same packing
//  req_ready  out  N_REQ    one-hot grant (combinational); transfer = valid[i] & ready[i]
//  dataA      out  4        to sumador.dataA (registered)
//  dataB      out  4        to sumador.dataB (registered)
//  sum30_dd   in   4        from sumador
//  rsp_valid  out  N_REQ    one-hot, 1-cycle pulse: result for requester i (registered)
//  rsp_sum    out  4        result, valid while any rsp_valid bit is high (registered)
//  drained    out  1        high in IDLE with zero in-flight operations
// BEHAVIOUR
//  Reset (reset_L=0, async): state=IDLE, rr_ptr=0, inflight=0, tag pipe cleared,
//   dataA=dataB=0, rsp_valid=0, rsp_sum=0, req_ready=0, drained=1.
//  FSM: IDLE --enable--> RUN --stop--> DRAIN --inflight==0--> IDLE.
//   Both enable and stop high in IDLE: go to RUN (stop is evaluated from RUN onward).
//   req_ready=0 in IDLE and DRAIN, and in RUN during any cycle with stop=1.
//  Arbitration (RUN, stop=0): scan i = rr_ptr, rr_ptr+1, ... mod N_REQ; grant first valid.
//   On transfer to i: rr_ptr <= (i+1) mod N_REQ. No valid requester: no grant, rr_ptr held.
//   At most one grant per cycle; req_ready never depends on req_ready.
//  Issue: transfer in cycle t -> dataA/dataB = operands of i during t+1, tag {1,i} enters
//   tag pipe. No transfer -> dataA=dataB=0 bubble with tag valid=0.
//  Tag pipe depth LAT: the tag exits aligned with sum30_dd for that operation (cycle t+1+LAT).
//  Response: rsp_valid[i]=1 and rsp_sum=sum30_dd during cycle t+2+LAT (total latency LAT+2;
//   4 at default). No back-pressure on responses; requesters must accept them.
//  Arithmetic: rsp_sum = (A+B) mod 16; carry discarded by the adder; no overflow flag.
//  inflight counter, width clog2(LAT+3): +1 on transfer, -1 on rsp_valid, unchanged if both.
//   Never exceeds LAT+2 by construction.
//  drained = (state==IDLE) && (inflight==0).
//  Reset mid-operation: all in-flight tags dropped, no responses emitted for them.
//   sumador shares reset_L.
// STRUCTURE
//  Package arbitro_pkg: state encoding (ST_IDLE, ST_RUN, ST_DRAIN), default N_REQ/LAT,
//   operand width constant W=4.
//  Sub-module sumador_tag_pipe: LAT-deep shift register of {valid, id[clog2(N_REQ)-1:0]},
//   async active-low clear.
//  Top holds FSM, rr pointer, grant logic, issue regs, response regs, inflight counter.
// TESTING (bench instantiates arbitro_sumador + sumador)
//  1. Reset held 3 cycles, enable=1; requester 0 only, A=3, B=4
//     -> req_ready=0001; rsp_valid=0001, rsp_sum=7 four cycles after transfer; drained=0 then 1
//     after stop.
//  2. All 4 valid every cycle, A=i, B=1
//     -> grants 0,1,2,3,0... one per cycle; rsp_valid sequence 0001,0010,0100,1000; sums 1,2,3,4.
//  3. Overflow: A=9, B=8 -> rsp_sum=1.
//     A=15, B=15 -> rsp_sum=14.
//  4. Drain: stop=1 with 3 in flight -> req_ready=0 that cycle; all 3 responses still
//     delivered; IDLE and drained=1 after the last.
//  5. reset_L=0 mid-stream with 2 in flight -> outputs zero immediately; no rsp_valid after
//     release; rr_ptr=0.
//  6. Sparse: only requesters 1 and 3 valid, rr_ptr=2 -> grant 3 then 1;
//     enable+stop together in IDLE -> RUN.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared definitions for the round-robin arbiter in front of the pipelined 4-bit adder.
package arbitro_pkg;
    localparam int W         = 4;
    localparam int N_REQ_DEF = 4;
    localparam int LAT_DEF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    // Width of a requester ID; a single requester still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sumador.sv
// Two-stage pipelined 4-bit adder; carry out is discarded.
module sumador
    import arbitro_pkg::*;
(
    input  logic         clk,
    input  logic         reset_L,
    input  logic [W-1:0] dataA,
    input  logic [W-1:0] dataB,
    output logic [W-1:0] sum30_dd
);

    logic [W-1:0] sum30_d_q;

    // Add in the first stage, re-time the result in the second.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sum30_d_q <= '0;
            sum30_dd  <= '0;
        end else begin
            sum30_d_q <= dataA + dataB;
            sum30_dd  <= sum30_d_q;
        end
    end

endmodule

// File: rtl/sumador_tag_pipe.sv
// LAT-deep shift register carrying {valid, requester id} alongside the adder pipeline.
module sumador_tag_pipe
    import arbitro_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int LAT   = LAT_DEF,
    localparam int IDW  = id_width(N_REQ)
) (
    input  logic           clk,
    input  logic           reset_L,
    input  logic           tag_valid_i,
    input  logic [IDW-1:0] tag_id_i,
    output logic           tag_valid_o,
    output logic [IDW-1:0] tag_id_o
);

    logic           valid_q [LAT];
    logic [IDW-1:0] id_q    [LAT];

    // Shift tags one stage per cycle; reset drops every in-flight tag.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int j = 0; j < LAT; j++) begin
                valid_q[j] <= 1'b0;
                id_q[j]    <= '0;
            end
        end else begin
            valid_q[0] <= tag_valid_i;
            id_q[0]    <= tag_id_i;
            for (int j = 1; j < LAT; j++) begin
                valid_q[j] <= valid_q[j-1];
                id_q[j]    <= id_q[j-1];
            end
        end
    end

    assign tag_valid_o = valid_q[LAT-1];
    assign tag_id_o    = id_q[LAT-1];

endmodule

// File: rtl/arbitro_sumador.sv
// Round-robin arbiter sharing one pipelined adder among N_REQ requesters, with tagged returns.
module arbitro_sumador
    import arbitro_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int LAT   = LAT_DEF
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               enable,
    input  logic               stop,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [W*N_REQ-1:0] req_dataA,
    input  logic [W*N_REQ-1:0] req_dataB,
    output logic [N_REQ-1:0]   req_ready,
    output logic [W-1:0]       dataA,
    output logic [W-1:0]       dataB,
    input  logic [W-1:0]       sum30_dd,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_sum,
    output logic               drained
);

    localparam int IDW = id_width(N_REQ);
    localparam int CW  = $clog2(LAT + 3);

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [W-1:0]     dataA_q, dataA_d, dataB_q, dataB_d;
    logic             tag_v_q, tag_v_d;
    logic [IDW-1:0]   tag_id_q, tag_id_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_sum_q, rsp_sum_d;

    logic             arb_en_s;
    logic [N_REQ-1:0] grant_s;
    logic [IDW-1:0]   grant_id_s;
    logic [IDW-1:0]   scan_id_s;
    logic             transfer_s;
    logic             rsp_any_s;
    logic             pipe_v_s;
    logic [IDW-1:0]   pipe_id_s;
    logic [W-1:0]     opa_s [N_REQ];
    logic [W-1:0]     opb_s [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign opa_s[g] = req_dataA[g*W +: W];
        assign opb_s[g] = req_dataB[g*W +: W];
    end

    // Grants are only offered in RUN on a cycle without a stop request.
    assign arb_en_s  = (state_q == ST_RUN) && !stop;
    assign rsp_any_s = |rsp_valid_q;

    // Round-robin scan from rr_ptr; the first valid requester wins and the pointer moves past it.
    always_comb begin
        grant_s    = '0;
        grant_id_s = '0;
        scan_id_s  = '0;
        transfer_s = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            scan_id_s = IDW'((int'(rr_ptr_q) + k) % N_REQ);
            if (arb_en_s && !transfer_s && req_valid[scan_id_s]) begin
                transfer_s          = 1'b1;
                grant_id_s          = scan_id_s;
                grant_s[scan_id_s]  = 1'b1;
                rr_ptr_d            = IDW'((int'(rr_ptr_q) + k + 1) % N_REQ);
            end else begin
                transfer_s = transfer_s;
            end
        end
    end

    // Sequencing: IDLE -> RUN on enable, RUN -> DRAIN on stop, DRAIN -> IDLE once nothing is in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
                else        state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (stop) state_d = ST_DRAIN;
                else      state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (inflight_q == '0) state_d = ST_IDLE;
                else                  state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue the granted operands to the adder, or a zero bubble with an invalid tag.
    always_comb begin
        dataA_d  = '0;
        dataB_d  = '0;
        tag_v_d  = 1'b0;
        tag_id_d = '0;
        if (transfer_s) begin
            dataA_d  = opa_s[grant_id_s];
            dataB_d  = opb_s[grant_id_s];
            tag_v_d  = 1'b1;
            tag_id_d = grant_id_s;
        end else begin
            tag_v_d  = 1'b0;
        end
    end

    // Route the adder result to the requester named by the tag leaving the pipe.
    always_comb begin
        rsp_valid_d = '0;
        rsp_sum_d   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pipe_v_s && (pipe_id_s == IDW'(i))) rsp_valid_d[i] = 1'b1;
            else                                     rsp_valid_d[i] = 1'b0;
        end
        if (pipe_v_s) rsp_sum_d = sum30_dd;
        else          rsp_sum_d = '0;
    end

    // Operations in flight: up on a transfer, down on a response, steady when both coincide.
    always_comb begin
        inflight_d = inflight_q;
        if (transfer_s && !rsp_any_s)      inflight_d = inflight_q + CW'(1);
        else if (!transfer_s && rsp_any_s) inflight_d = inflight_q - CW'(1);
        else                               inflight_d = inflight_q;
    end

    // All control, issue and response state.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            inflight_q  <= '0;
            dataA_q     <= '0;
            dataB_q     <= '0;
            tag_v_q     <= 1'b0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            inflight_q  <= inflight_d;
            dataA_q     <= dataA_d;
            dataB_q     <= dataB_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
        end
    end

    sumador_tag_pipe #(
        .N_REQ (N_REQ),
        .LAT   (LAT)
    ) u_tag_pipe (
        .clk         (clk),
        .reset_L     (reset_L),
        .tag_valid_i (tag_v_q),
        .tag_id_i    (tag_id_q),
        .tag_valid_o (pipe_v_s),
        .tag_id_o    (pipe_id_s)
    );

    assign req_ready = grant_s;
    assign dataA     = dataA_q;
    assign dataB     = dataB_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign drained   = (state_q == ST_IDLE) && (inflight_q == '0);

endmodule

// File: tb/tb_arbitro_sumador.sv
// Directed bench for arbitro_sumador driving a real sumador.
module tb_arbitro_sumador;

    logic        clk;
    logic        reset_L;
    logic        enable;
    logic        stop;
    logic [3:0]  req_valid;
    logic [15:0] req_dataA;
    logic [15:0] req_dataB;
    logic [3:0]  req_ready;
    logic [3:0]  dataA;
    logic [3:0]  dataB;
    logic [3:0]  sum30_dd;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_sum;
    logic        drained;

    int n_checks;
    int n_fail;

    arbitro_sumador #(.N_REQ(4), .LAT(2)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .enable    (enable),
        .stop      (stop),
        .req_valid (req_valid),
        .req_dataA (req_dataA),
        .req_dataB (req_dataB),
        .req_ready (req_ready),
        .dataA     (dataA),
        .dataB     (dataB),
        .sum30_dd  (sum30_dd),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .drained   (drained)
    );

    sumador u_sum (
        .clk      (clk),
        .reset_L  (reset_L),
        .dataA    (dataA),
        .dataB    (dataB),
        .sum30_dd (sum30_dd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle: inputs change on the falling edge, outputs sampled 1 time unit later.
    task automatic drive(input logic [3:0] v, input logic en, input logic st);
        @(negedge clk);
        req_valid = v;
        enable    = en;
        stop      = st;
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset_L   = 1'b0;
        enable    = 1'b0;
        stop      = 1'b0;
        req_valid = 4'b0000;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_reset;
        reset_L   = 1'b0;
        enable    = 1'b1;
        stop      = 1'b0;
        req_valid = 4'b1111;
        req_dataA = 16'h0000;
        req_dataB = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        n_checks++; if (dataA !== 4'd0 || dataB !== 4'd0) begin n_fail++; $display("FAIL reset_data: got %h/%h expected 0/0", dataA, dataB); end
        n_checks++; if (rsp_valid !== 4'b0000 || rsp_sum !== 4'd0) begin n_fail++; $display("FAIL reset_rsp: got %b/%h expected 0000/0", rsp_valid, rsp_sum); end
        n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL reset_drained: got %b expected 1", drained); end
        @(negedge clk);
        enable    = 1'b0;
        req_valid = 4'b0000;
        reset_L   = 1'b1;
    endtask

    task automatic test_single;
        logic [3:0] exp_v;
        logic [3:0] exp_s;
        req_dataA = {4'd0, 4'd0, 4'd0, 4'd3};
        req_dataB = {4'd0, 4'd0, 4'd0, 4'd4};
        drive(4'b0001, 1'b1, 1'b0);
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_idle_ready: got %b expected 0000", req_ready); end
        drive(4'b0001, 1'b1, 1'b0);
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
        n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL single_run_drained: got %b expected 0", drained); end
        for (int k = 2; k <= 6; k++) begin
            drive(4'b0000, 1'b1, 1'b0);
            exp_v = (k == 5) ? 4'b0001 : 4'b0000;
            exp_s = (k == 5) ? 4'd7 : 4'd0;
            n_checks++; if (rsp_valid !== exp_v || rsp_sum !== exp_s) begin n_fail++; $display("FAIL single_rsp c%0d: got %b/%0d expected %b/%0d", k, rsp_valid, rsp_sum, exp_v, exp_s); end
        end
        n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL single_pre_stop_drained: got %b expected 0", drained); end
        for (int k = 0; k < 6; k++) begin
            drive(4'b0000, 1'b0, 1'b1);
            if (drained === 1'b1) break;
        end
        n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL single_drained_after_stop: got %b expected 1", drained); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_r;
        logic [3:0] exp_v;
        logic [3:0] exp_s;
        logic [3:0] v;
        do_reset();
        req_dataA = {4'd3, 4'd2, 4'd1, 4'd0};
        req_dataB = {4'd1, 4'd1, 4'd1, 4'd1};
        drive(4'b1111, 1'b1, 1'b0);
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_idle_ready: got %b expected 0000", req_ready); end
        for (int k = 1; k <= 10; k++) begin
            v = (k <= 5) ? 4'b1111 : 4'b0000;
            drive(v, 1'b1, 1'b0);
            exp_r = (k <= 5) ? (4'b0001 << ((k - 1) % 4)) : 4'b0000;
            n_checks++; if (req_ready !== exp_r) begin n_fail++; $display("FAIL rr_grant c%0d: got %b expected %b", k, req_ready, exp_r); end
            if (k == 3) begin
                n_checks++; if (dataA !== 4'd1 || dataB !== 4'd1) begin n_fail++; $display("FAIL rr_issue c3: got %0d/%0d expected 1/1", dataA, dataB); end
            end
            exp_v = (k >= 5 && k <= 9) ? (4'b0001 << ((k - 5) % 4)) : 4'b0000;
            exp_s = (k >= 5 && k <= 9) ? 4'(((k - 5) % 4) + 1) : 4'd0;
            n_checks++; if (rsp_valid !== exp_v || rsp_sum !== exp_s) begin n_fail++; $display("FAIL rr_rsp c%0d: got %b/%0d expected %b/%0d", k, rsp_valid, rsp_sum, exp_v, exp_s); end
        end
    endtask

    task automatic test_overflow;
        logic [3:0] exp_v;
        logic [3:0] exp_s;
        do_reset();
        req_dataA = {4'd0, 4'd0, 4'd0, 4'd9};
        req_dataB = {4'd0, 4'd0, 4'd0, 4'd8};
        drive(4'b0001, 1'b1, 1'b0);
        drive(4'b0001, 1'b1, 1'b0);
        drive(4'b0001, 1'b1, 1'b0);
        req_dataA = {4'd0, 4'd0, 4'd0, 4'd15};
        req_dataB = {4'd0, 4'd0, 4'd0, 4'd15};
        for (int k = 3; k <= 7; k++) begin
            drive(4'b0000, 1'b1, 1'b0);
            exp_v = (k == 5 || k == 6) ? 4'b0001 : 4'b0000;
            exp_s = (k == 5) ? 4'd1 : ((k == 6) ? 4'd14 : 4'd0);
            n_checks++; if (rsp_valid !== exp_v || rsp_sum !== exp_s) begin n_fail++; $display("FAIL overflow_rsp c%0d: got %b/%0d expected %b/%0d", k, rsp_valid, rsp_sum, exp_v, exp_s); end
        end
    endtask

    task automatic test_drain;
        logic [3:0] exp_v;
        logic [3:0] exp_s;
        do_reset();
        req_dataA = {4'd7, 4'd6, 4'd5, 4'd4};
        req_dataB = {4'd1, 4'd1, 4'd1, 4'd1};
        drive(4'b1111, 1'b1, 1'b0);
        drive(4'b1111, 1'b1, 1'b0);
        drive(4'b1111, 1'b1, 1'b0);
        drive(4'b1111, 1'b1, 1'b0);
        drive(4'b1111, 1'b0, 1'b1);
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL drain_stop_ready: got %b expected 0000", req_ready); end
        for (int k = 5; k <= 9; k++) begin
            drive(4'b1111, 1'b0, 1'b0);
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL drain_ready c%0d: got %b expected 0000", k, req_ready); end
            exp_v = (k <= 7) ? (4'b0001 << (k - 5)) : 4'b0000;
            exp_s = (k <= 7) ? 4'(k) : 4'd0;
            n_checks++; if (rsp_valid !== exp_v || rsp_sum !== exp_s) begin n_fail++; $display("FAIL drain_rsp c%0d: got %b/%0d expected %b/%0d", k, rsp_valid, rsp_sum, exp_v, exp_s); end
            n_checks++; if (drained !== (k == 9)) begin n_fail++; $display("FAIL drain_drained c%0d: got %b expected %b", k, drained, (k == 9)); end
        end
    endtask

    task automatic test_reset_midstream;
        do_reset();
        req_dataA = {4'd1, 4'd1, 4'd1, 4'd1};
        req_dataB = {4'd1, 4'd1, 4'd1, 4'd1};
        drive(4'b1111, 1'b1, 1'b0);
        drive(4'b1111, 1'b1, 1'b0);
        drive(4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        reset_L = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0000 || dataA !== 4'd0 || dataB !== 4'd0) begin n_fail++; $display("FAIL midreset_outputs: got %b/%0d/%0d expected 0000/0/0", req_ready, dataA, dataB); end
        n_checks++; if (rsp_valid !== 4'b0000 || drained !== 1'b1) begin n_fail++; $display("FAIL midreset_rsp: got %b/%b expected 0000/1", rsp_valid, drained); end
        enable    = 1'b0;
        req_valid = 4'b0000;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(4'b0000, 1'b0, 1'b0);
            n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL midreset_no_rsp c%0d: got %b expected 0000", k, rsp_valid); end
        end
        drive(4'b1111, 1'b1, 1'b0);
        drive(4'b1111, 1'b1, 1'b0);
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midreset_rr_ptr: got %b expected 0001", req_ready); end
    endtask

    task automatic test_sparse;
        do_reset();
        drive(4'b0011, 1'b1, 1'b1);
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL sparse_idle_ready: got %b expected 0000", req_ready); end
        drive(4'b0011, 1'b1, 1'b0);
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL sparse_enable_stop_run: got %b expected 0001", req_ready); end
        drive(4'b0011, 1'b1, 1'b0);
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL sparse_second: got %b expected 0010", req_ready); end
        drive(4'b1010, 1'b1, 1'b0);
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL sparse_grant3: got %b expected 1000", req_ready); end
        drive(4'b1010, 1'b1, 1'b0);
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL sparse_grant1: got %b expected 0010", req_ready); end
        drive(4'b0000, 1'b0, 1'b1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_L   = 1'b0;
        enable    = 1'b0;
        stop      = 1'b0;
        req_valid = 4'b0000;
        req_dataA = 16'h0000;
        req_dataB = 16'h0000;
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_drain();
        test_reset_midstream();
        test_sparse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
